// File: rtl/rv_imm_pkg.sv
// Immediate-decode types, opcode constants and the shared extraction helper.
// imm_extract always returns a 64-bit value; callers truncate to their XLEN.
package rv_imm_pkg;

  typedef enum logic [2:0] {
    IMM_R = 3'd0,
    IMM_I = 3'd1,
    IMM_S = 3'd2,
    IMM_B = 3'd3,
    IMM_U = 3'd4,
    IMM_J = 3'd5,
    IMM_Z = 3'd6
  } imm_type_e;

  localparam logic [6:0] OPC_LOAD      = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE     = 7'b0100011;
  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_LUI       = 7'b0110111;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_JALR      = 7'b1100111;
  localparam logic [6:0] OPC_JAL       = 7'b1101111;
  localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;

  function automatic logic [63:0] imm_extract(imm_type_e t, logic [31:0] instr);
    logic [63:0] imm;
    logic        unused_opc;
    unused_opc = ^instr[6:0];
    imm        = '0;
    case (t)
      IMM_I:   imm = {{52{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{51{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      IMM_J:   imm = {{43{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      IMM_Z:   imm = {59'b0, instr[19:15]};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/imm_skid_buffer.sv
// Two-entry valid/ready stage: one output register plus one skid entry.
// ready_o depends only on the skid flag and rst, never on ready_i.
module imm_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         valid_i,
  output logic         ready_o,
  input  logic [W-1:0] data_i,
  output logic         valid_o,
  input  logic         ready_i,
  output logic [W-1:0] data_o
);

  logic         out_valid_q, out_valid_d;
  logic         skid_valid_q, skid_valid_d;
  logic [W-1:0] out_data_q, out_data_d;
  logic [W-1:0] skid_data_q, skid_data_d;
  logic         accept;
  logic         out_free;

  assign ready_o  = ~skid_valid_q & ~rst;
  assign accept   = valid_i & ready_o;
  assign out_free = ~out_valid_q | ready_i;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    if (out_free) begin
      // A held skid entry always has priority so ordering stays FIFO.
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = data_i;
      end
    end else if (accept) begin
      skid_valid_d = 1'b1;
      skid_data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign valid_o = out_valid_q;
  assign data_o  = out_data_q;

endmodule

// File: rtl/imm_decode_pipe.sv
// Opcode-driven immediate decoder registered behind a two-entry skid stage.
// Optional IMM_DECODE_ZICSR_EN: CSR*I forms report type Z with a 5-bit zero-extended uimm.
module imm_decode_pipe
  import rv_imm_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [2:0]       out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  localparam int PW = XLEN + 3 + 1 + TAG_W;

  imm_type_e       dec_type;
  logic            dec_illegal;
  logic [63:0]     imm_full;
  logic [XLEN-1:0] dec_imm;
  logic            unused_imm;
  logic [PW-1:0]   pl_in;
  logic [PW-1:0]   pl_out;

  always_comb begin
    dec_type    = IMM_R;
    dec_illegal = 1'b0;
    if (in_instr[1:0] != 2'b11) begin
      dec_illegal = 1'b1;
    end else begin
      case (in_instr[6:0])
        OPC_LOAD, OPC_OP_IMM, OPC_JALR: dec_type = IMM_I;
        OPC_SYSTEM: begin
          dec_type = IMM_I;
`ifdef IMM_DECODE_ZICSR_EN
          if (in_instr[14]) dec_type = IMM_Z;
`endif
        end
        OPC_STORE:          dec_type = IMM_S;
        OPC_BRANCH:         dec_type = IMM_B;
        OPC_LUI, OPC_AUIPC: dec_type = IMM_U;
        OPC_JAL:            dec_type = IMM_J;
        OPC_OP:             dec_type = IMM_R;
        OPC_OP_IMM_32: begin
          if (XLEN == 64) dec_type = IMM_I;
          else            dec_illegal = 1'b1;
        end
        OPC_OP_32: begin
          if (XLEN != 64) dec_illegal = 1'b1;
        end
        default:            dec_illegal = 1'b1;
      endcase
    end
  end

  // Illegal decodes leave dec_type at R, which extracts to zero.
  assign imm_full   = imm_extract(dec_type, in_instr);
  assign dec_imm    = imm_full[XLEN-1:0];
  assign unused_imm = ^imm_full;
  assign pl_in      = {dec_imm, dec_type, dec_illegal, in_tag};

  imm_skid_buffer #(
    .W(PW)
  ) u_skid (
    .clk     (clk),
    .rst     (rst),
    .valid_i (in_valid),
    .ready_o (in_ready),
    .data_i  (pl_in),
    .valid_o (out_valid),
    .ready_i (out_ready),
    .data_o  (pl_out)
  );

  assign {out_imm, out_type, out_illegal, out_tag} = pl_out;

endmodule

// File: tb/tb_imm_decode_pipe.sv
// Scoreboard bench for imm_decode_pipe: a 32-bit and a 64-bit instance share stimulus.
// Expected results are pushed at acceptance and popped by a negedge monitor.
module tb_imm_decode_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid  = 1'b0;
  logic        out_ready = 1'b1;
  logic [31:0] in_instr  = '0;
  logic [7:0]  in_tag    = '0;

  logic        rdy32, ov32, ill32;
  logic [31:0] imm32;
  logic [2:0]  ty32;
  logic [7:0]  tag32;
  logic        rdy64, ov64, ill64;
  logic [63:0] imm64;
  logic [2:0]  ty64;
  logic [7:0]  tag64;

  imm_decode_pipe #(.XLEN(32), .TAG_W(8)) dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(ov32), .out_ready(out_ready), .out_imm(imm32),
    .out_type(ty32), .out_illegal(ill32), .out_tag(tag32));

  imm_decode_pipe #(.XLEN(64), .TAG_W(8)) dut64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr),
    .in_tag(in_tag), .out_valid(ov64), .out_ready(out_ready), .out_imm(imm64),
    .out_type(ty64), .out_illegal(ill64), .out_tag(tag64));

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  t32;
    logic        i32;
    logic [2:0]  t64;
    logic        i64;
    logic [63:0] imm64;
  } vec_t;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  ty;
    logic        ill;
    logic [7:0]  tag;
    int          cyc;
    bit          lat;
  } exp_t;

  vec_t vecs[$];
  exp_t q32[$];
  exp_t q64[$];
  exp_t cur32, cur64;
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  bit   lat_mode = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [31:0] instr, input logic [2:0] t32, input logic i32,
                         input logic [2:0] t64, input logic i64, input logic [63:0] imm);
    vec_t v;
    v.instr = instr; v.t32 = t32; v.i32 = i32; v.t64 = t64; v.i64 = i64; v.imm64 = imm;
    vecs.push_back(v);
  endtask

  task automatic put(input int i, input logic [7:0] tag);
    vec_t v;
    v        = vecs[i];
    in_valid = 1'b1;
    in_instr = v.instr;
    in_tag   = tag;
    cur32.imm = v.i32 ? 64'h0 : {32'h0, v.imm64[31:0]};
    cur32.ty  = v.t32;
    cur32.ill = v.i32;
    cur32.tag = tag;
    cur64.imm = v.i64 ? 64'h0 : v.imm64;
    cur64.ty  = v.t64;
    cur64.ill = v.i64;
    cur64.tag = tag;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input logic [7:0] tag, output int tries);
    bit acc;
    put(i, tag);
    tries = 0;
    acc   = 1'b0;
    while (!acc && tries < 20) begin
      @(negedge clk);
      acc = rdy32;
      tick();
      tries++;
    end
    if (!acc) begin
      total++; bad++;
      $display("FAIL send_timeout: vector %0d not accepted, want accept", i);
    end
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q64.size() != 0) && n < 40) begin
      tick();
      n++;
    end
    chk("drain32", 64'(q32.size()), 64'd0);
    chk("drain64", 64'(q64.size()), 64'd0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (ov32 && out_ready) begin
        if (q32.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected32: got tag %0h want no output", tag32);
        end else begin
          e = q32.pop_front();
          chk("imm32", 64'(imm32), e.imm);
          chk("type32", 64'(ty32), 64'(e.ty));
          chk("illegal32", 64'(ill32), 64'(e.ill));
          chk("tag32", 64'(tag32), 64'(e.tag));
          if (e.lat) chk("latency32", 64'(cyc), 64'(e.cyc + 1));
        end
      end
      if (ov64 && out_ready) begin
        if (q64.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected64: got tag %0h want no output", tag64);
        end else begin
          e = q64.pop_front();
          chk("imm64", imm64, e.imm);
          chk("type64", 64'(ty64), 64'(e.ty));
          chk("illegal64", 64'(ill64), 64'(e.ill));
          chk("tag64", 64'(tag64), 64'(e.tag));
          if (e.lat) chk("latency64", 64'(cyc), 64'(e.cyc + 1));
        end
      end
      if (in_valid && rdy32) begin
        e = cur32; e.cyc = cyc; e.lat = lat_mode;
        q32.push_back(e);
      end
      if (in_valid && rdy64) begin
        e = cur64; e.cyc = cyc; e.lat = lat_mode;
        q64.push_back(e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int tries;
    // instr, type32, ill32, type64, ill64, imm (64-bit view)
    add_vec(32'hFFF00093, 3'd1, 1'b0, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF); // 0 addi -1
    add_vec(32'hFE112E23, 3'd2, 1'b0, 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC); // 1 sw -4
    add_vec(32'hFF9FF06F, 3'd5, 1'b0, 3'd5, 1'b0, 64'hFFFF_FFFF_FFFF_FFF8); // 2 jal -8
    add_vec(32'h123452B7, 3'd4, 1'b0, 3'd4, 1'b0, 64'h0000_0000_1234_5000); // 3 lui
    add_vec(32'h800002B7, 3'd4, 1'b0, 3'd4, 1'b0, 64'hFFFF_FFFF_8000_0000); // 4 lui neg
    add_vec(32'h00000000, 3'd0, 1'b1, 3'd0, 1'b1, 64'h0);                   // 5 illegal
`ifdef IMM_DECODE_ZICSR_EN
    add_vec(32'h3002D073, 3'd6, 1'b0, 3'd6, 1'b0, 64'h5);                   // 6 csrrwi
`else
    add_vec(32'h3002D073, 3'd1, 1'b0, 3'd1, 1'b0, 64'h300);                 // 6 csrrwi
`endif
    add_vec(32'hFE000EE3, 3'd3, 1'b0, 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC); // 7 beq -4
    add_vec(32'h002081B3, 3'd0, 1'b0, 3'd0, 1'b0, 64'h0);                   // 8 add
    add_vec(32'h0050809B, 3'd0, 1'b1, 3'd1, 1'b0, 64'h5);                   // 9 addiw
    add_vec(32'h002081BB, 3'd0, 1'b1, 3'd0, 1'b0, 64'h0);                   // 10 addw
    add_vec(32'h00000010, 3'd0, 1'b1, 3'd0, 1'b1, 64'h0);                   // 11 bad low bits
    add_vec(32'h7FF02083, 3'd1, 1'b0, 3'd1, 1'b0, 64'h7FF);                 // 12 lw 2047
    add_vec(32'hFFFFF097, 3'd4, 1'b0, 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_F000); // 13 auipc
    add_vec(32'h30029073, 3'd1, 1'b0, 3'd1, 1'b0, 64'h300);                 // 14 csrrw
    add_vec(32'h800080E7, 3'd1, 1'b0, 3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_F800); // 15 jalr

    // reset state
    tick();
    @(negedge clk);
    chk("rst_ready_low", 64'(rdy32), 64'd0);
    chk("rst_valid_low", 64'(ov32), 64'd0);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 64'(rdy32), 64'd1);
    chk("rst_out_imm", 64'(imm32), 64'd0);
    chk("rst_out_type", 64'(ty32), 64'd0);
    chk("rst_out_illegal", 64'(ill32), 64'd0);
    chk("rst_out_tag", 64'(tag32), 64'd0);
    tick();

    // back-to-back stream, consumer always ready
    lat_mode  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      send(i, 8'h10 + 8'(i), tries);
      chk("throughput", 64'(tries), 64'd1);
    end
    in_valid = 1'b0;
    wait_drain();
    lat_mode = 1'b0;

    // mid-stream stall of three cycles
    put(0, 8'hA0);
    tick();                                   // A -> output register
    out_ready = 1'b0;
    put(1, 8'hA1);
    @(negedge clk);
    chk("ready_before_fill", 64'(rdy32), 64'd1);
    tick();                                   // B -> skid
    put(2, 8'hA2);
    @(negedge clk);
    chk("ready_fall", 64'(rdy32), 64'd0);
    chk("stall_tag", 64'(tag32), 64'hA0);
    tick();
    @(negedge clk);
    chk("ready_hold", 64'(rdy32), 64'd0);
    chk("stall_tag_hold", 64'(tag32), 64'hA0);
    chk("stall_imm_hold", 64'(imm32), 64'hFFFF_FFFF);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    chk("ready_still_low", 64'(rdy32), 64'd0);
    tick();                                   // A drains, B moves up
    @(negedge clk);
    chk("ready_rise", 64'(rdy32), 64'd1);
    tick();                                   // B drains, C loads directly
    put(3, 8'hA3);
    tick();
    put(12, 8'hA4);
    tick();
    in_valid = 1'b0;
    wait_drain();

    // reset while both entries are held
    out_ready = 1'b0;
    put(7, 8'hB0);
    tick();
    put(8, 8'hB1);
    tick();
    put(13, 8'hB2);
    rst = 1'b1;
    q32.delete();
    q64.delete();
    @(negedge clk);
    chk("rst_mid_ready", 64'(rdy32), 64'd0);
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("rst_flush_valid", 64'(ov32), 64'd0);
    chk("rst_flush_valid64", 64'(ov64), 64'd0);
    chk("rst_ready_back", 64'(rdy32), 64'd1);
    tick();                                   // B2 accepted after reset
    in_valid = 1'b0;
    wait_drain();

    repeat (3) tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_decode_pipe.md
# imm_decode_pipe

Registered, handshaked immediate decoder and the parametrised successor to the combinational immediate extender. It decodes the immediate format directly from the opcode instead of taking an external select, and sign-extends to XLEN (32 or 64). It adds U-type, RV64 word opcodes and an illegal-opcode flag. It sits between fetch and execute as one valid/ready pipeline stage with a skid buffer, so back-pressure never drops an instruction.

## Interface
- XLEN, 32, datapath width; legal values 32 or 64.
- TAG_W, 8, width of the sideband tag carried alongside each instruction, such as a PC slice or ROB id.
- clk  in  1  clock; the block has one clock only.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction present on input.
- in_ready  out  1  block can accept an input.
- in_instr  in  32  raw instruction word.
- in_tag  in  TAG_W  sideband tag; passed through unchanged.
- out_valid  out  1  decoded result present.
- out_ready  in  1  consumer accepts the result.
- out_imm  out  XLEN  extended immediate.
- out_type  out  3  imm_type_e: R=0, I=1, S=2, B=3, U=4, J=5, Z=6.
- out_illegal  out  1  unrecognised opcode.
- out_tag  out  TAG_W  tag of the result.

## Operation
- A transfer occurs on a rising edge where valid and ready are both high, on either port.
- Opcode to type mapping (instr[6:0]):
  - LOAD 0000011, OP-IMM 0010011, JALR 1100111, SYSTEM 1110011 → I.
  - STORE 0100011 → S.
  - BRANCH 1100011 → B.
  - LUI 0110111, AUIPC 0010111 → U.
  - JAL 1101111 → J.
  - OP 0110011 → R.
- OP-IMM-32 0011011 → I and OP-32 0111011 → R only when XLEN=64; both are illegal when XLEN=32.
- Immediate formats (sign bit is instr[31]):
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: sext({instr[31:12], 12'b0}).
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R: 0.
- Illegal: instr[1:0] != 2'b11 or opcode not in the table. Result is out_illegal=1, out_type=R, out_imm=0; it still flows through the pipe in order.
- Buffering is one output register plus one skid entry, for two entries total.
- in_ready = !skid_valid, taken from a register with no combinational path from out_ready.
- When the output register is occupied and out_ready is low, the next accepted input goes to the skid entry and in_ready falls on the following cycle.
- When the output drains, the skid entry moves into the output register and in_ready rises on the following cycle.
- Ordering is strictly FIFO and there is no loss or duplication.

## Timing
- Latency is 1 cycle: an input accepted at edge N appears on out_* after edge N.
- Throughput is 1 per cycle while out_ready is held high.
- Reset values are out_valid=0, out_imm=0, out_type=R, out_illegal=0, out_tag=0, and skid entry empty.
- in_ready is forced 0 while rst=1 and is 1 on the first cycle after rst deasserts.
- Reset mid-stream discards both entries; the inputs presented in that cycle are ignored.
- If out_ready is low and both entries are full, out_* stay stable and in_ready=0.
- Simultaneous drain and accept with the skid empty: the output register reloads directly from the input in the same edge.

## Configuration
- Macro IMM_DECODE_ZICSR_EN.
- Defined: SYSTEM with funct3[2]=1 (CSRRWI, CSRRSI, CSRRCI) → type Z, out_imm = zero-extended instr[19:15]. All other SYSTEM encodings stay I.
- Undefined: every SYSTEM encoding → I with sign extension, and type Z is never produced.

## Structure
- Package rv_imm_pkg holds imm_type_e, the opcode localparams, and a function imm_extract(type, instr) returning a 64-bit sign-extended value that the block truncates to XLEN.
- Sub-module imm_skid_buffer, parametrised on payload width, implements the two-entry valid/ready storage.
- The top level holds only the decode logic plus one instance of imm_skid_buffer.

## Test plan
- 0xFFF00093 (addi x1,x0,-1) with out_ready=1 → one cycle later type I, out_imm=0xFFFFFFFF, out_illegal=0, tag echoed.
- Back-to-back 0xFE112E23 (sw -4) then 0xFF9FF06F (jal x0,-8) → S with 0xFFFFFFFC, then J with 0xFFFFFFF8, on consecutive cycles.
- 0x123452B7 (lui) → U, 0x12345000.
- XLEN=64 with 0x800002B7 → 0xFFFFFFFF80000000.
- Five-instruction stream, out_ready low for 3 cycles mid-stream → in_ready low exactly one cycle after the skid fills, and all 5 results arrive in order with matching tags.
- 0x00000000 → out_illegal=1, out_imm=0, type R.
- Assert rst while two entries are held → out_valid=0 next cycle and in_ready=1 the cycle after rst falls.
- 0x3002D073 (csrrwi x0,0x300,5) → with IMM_DECODE_ZICSR_EN: Z, out_imm=5. Without the macro: I, out_imm=0x300.
